// File: rtl/viterbi_puncture_pkg.sv
// Shared Viterbi constants: puncture period limits and the default keep masks
// for the standard code rates, plus small helpers used by the puncturer path.
package viterbi_puncture_pkg;

    localparam int MIN_P = 2;
    localparam int MAX_P = 8;
    localparam int COL_W = 3;

    // Rate 1/2: nothing punctured.
    localparam int               RATE12_P    = 2;
    localparam logic [MAX_P-1:0] RATE12_POL0 = 8'b0000_0011;
    localparam logic [MAX_P-1:0] RATE12_POL1 = 8'b0000_0011;

    // Rate 2/3: three coded bits out of every two symbols.
    localparam int               RATE23_P    = 2;
    localparam logic [MAX_P-1:0] RATE23_POL0 = 8'b0000_0011;
    localparam logic [MAX_P-1:0] RATE23_POL1 = 8'b0000_0001;

    // Rate 3/4: four coded bits out of every three symbols.
    localparam int               RATE34_P    = 3;
    localparam logic [MAX_P-1:0] RATE34_POL0 = 8'b0000_0101;
    localparam logic [MAX_P-1:0] RATE34_POL1 = 8'b0000_0011;

    // Number of bits requested by a per-bit write enable pair (0, 1 or 2).
    function automatic logic [1:0] push_count(input logic [1:0] en);
        return {1'b0, en[0]} + {1'b0, en[1]};
    endfunction

    // True when a depth is a power of two and at least four entries deep.
    function automatic bit depth_ok(input int depth);
        return (depth >= 4) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/viterbi_bit_fifo.sv
// Serialising bit FIFO: up to two bits written per cycle (lane 0 first),
// one bit read per cycle, head presented combinationally with its valid.
module viterbi_bit_fifo
    import viterbi_puncture_pkg::*;
#(
    parameter int p_depth = 8,
    parameter int PTR_W   = $clog2(p_depth),
    parameter int CNT_W   = $clog2(p_depth) + 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [1:0]       i_wr_en,
    input  logic [1:0]       i_wr_data,
    input  logic             i_rd_en,
    output logic             o_rd_data,
    output logic             o_rd_valid,
    output logic [CNT_W-1:0] o_count
);

    if (!depth_ok(p_depth)) begin : g_bad_depth
        $error("viterbi_bit_fifo: p_depth must be a power of two and >= 4");
    end

    logic [p_depth-1:0] mem;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr_p1;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   free;
    logic [1:0]         n_push;
    logic [1:0]         n_eff;
    logic               lane0;
    logic               pop;
    logic               wr_ok;

    // Compact the enabled bits into consecutive slots and qualify push/pop.
    always_comb begin
        n_push    = push_count(i_wr_en);
        lane0     = i_wr_en[0] ? i_wr_data[0] : i_wr_data[1];
        free      = CNT_W'(p_depth) - count;
        wr_ok     = CNT_W'(n_push) <= free;
        n_eff     = wr_ok ? n_push : 2'd0;
        pop       = i_rd_en && (count != '0);
        wr_ptr_p1 = wr_ptr + PTR_W'(1);
    end

    // Pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(n_eff);
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count  <= count + CNT_W'(n_eff) - CNT_W'(pop);
        end
    end

    // Storage is not reset; the head is masked whenever the FIFO is empty.
    always_ff @(posedge i_clk) begin
        if (n_eff != 2'd0) begin
            mem[wr_ptr] <= lane0;
        end
        if (n_eff == 2'd2) begin
            mem[wr_ptr_p1] <= i_wr_data[1];
        end
    end

    assign o_rd_valid = (count != '0);
    assign o_rd_data  = o_rd_valid ? mem[rd_ptr] : 1'b0;
    assign o_count    = count;

endmodule

// File: rtl/viterbi_puncture.sv
// Puncturer: drops coded bits according to per-column keep masks and
// serialises the surviving bits through a small bit FIFO.
module viterbi_puncture
    import viterbi_puncture_pkg::*;
#(
    parameter int               p_speed_size = RATE34_P,
    parameter logic [MAX_P-1:0] p_speed_pol0 = RATE34_POL0,
    parameter logic [MAX_P-1:0] p_speed_pol1 = RATE34_POL1,
    parameter int               p_fifo_depth = 8
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [1:0] i_data,
    input  logic       i_valid,
    input  logic       i_sync,
    output logic       o_ready,
    output logic       o_data,
    output logic       o_valid,
    input  logic       i_ready
);

    localparam int         CNT_W    = $clog2(p_fifo_depth) + 1;
    localparam logic [2:0] LAST_COL = 3'(p_speed_size - 1);

    if ((p_speed_size < MIN_P) || (p_speed_size > MAX_P)) begin : g_bad_size
        $error("viterbi_puncture: p_speed_size must be within 2..8");
    end

    logic [COL_W-1:0] col;
    logic [COL_W-1:0] cur_col;
    logic [COL_W-1:0] col_next;
    logic [1:0]       wr_en;
    logic [CNT_W-1:0] occupancy;
    logic [CNT_W-1:0] free;
    logic             accept;

    // Handshake, column selection (sync forces column 0) and keep decision.
    always_comb begin
        free     = CNT_W'(p_fifo_depth) - occupancy;
        o_ready  = free >= CNT_W'(2);
        accept   = i_valid && o_ready;
        cur_col  = i_sync ? '0 : col;
        col_next = (cur_col == LAST_COL) ? '0 : cur_col + COL_W'(1);
        wr_en    = 2'b00;
        if (accept) begin
            wr_en = {p_speed_pol1[cur_col], p_speed_pol0[cur_col]};
        end
    end

    // Column counter advances on every accepted symbol, kept bits or not.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            col <= '0;
        end else if (accept) begin
            col <= col_next;
        end
    end

    viterbi_bit_fifo #(
        .p_depth (p_fifo_depth)
    ) u_fifo (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_wr_en    (wr_en),
        .i_wr_data  (i_data),
        .i_rd_en    (i_ready),
        .o_rd_data  (o_data),
        .o_rd_valid (o_valid),
        .o_count    (occupancy)
    );

endmodule

// File: tb/tb_viterbi_puncture.sv
module tb_viterbi_puncture;

    localparam int DEPTH = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [1:0] a_data, b_data;
    logic       a_valid, a_sync, a_ready;
    logic       b_valid, b_sync, b_ready;
    logic       a_o_ready, a_o_data, a_o_valid;
    logic       b_o_ready, b_o_data, b_o_valid;

    viterbi_puncture #(.p_fifo_depth(DEPTH)) dut_a (
        .i_clk(clk), .i_reset(rst_n), .i_data(a_data), .i_valid(a_valid),
        .i_sync(a_sync), .o_ready(a_o_ready), .o_data(a_o_data),
        .o_valid(a_o_valid), .i_ready(a_ready)
    );

    viterbi_puncture #(
        .p_speed_size(2), .p_speed_pol0(8'b11), .p_speed_pol1(8'b01),
        .p_fifo_depth(DEPTH)
    ) dut_b (
        .i_clk(clk), .i_reset(rst_n), .i_data(b_data), .i_valid(b_valid),
        .i_sync(b_sync), .o_ready(b_o_ready), .o_data(b_o_data),
        .o_valid(b_o_valid), .i_ready(b_ready)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Compare a captured bit stream with an expected one (bit i = i-th output).
    task automatic chk_bits(input string name, input bit got[$], input logic [15:0] exp, input int n);
        chk({name, "_len"}, got.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < got.size()) chk($sformatf("%s_bit%0d", name, i), got[i], exp[i]);
        end
    endtask

    // Reference model: symbols since last sync/reset select the column by
    // modulo; kept bits go to an ideal queue; ready means two free slots.
    bit qa[$], qb[$];
    int ka, kb;
    bit m_ok = 0;
    logic [7:0] ma0 = 8'b101, ma1 = 8'b011;
    logic [7:0] mb0 = 8'b11,  mb1 = 8'b01;

    always @(posedge clk) begin
        bit acc_a, acc_b;
        int c;
        if (!rst_n) begin
            qa.delete(); qb.delete(); ka = 0; kb = 0; m_ok = 1;
        end else if (m_ok) begin
            acc_a = a_valid && ((DEPTH - qa.size()) >= 2);
            acc_b = b_valid && ((DEPTH - qb.size()) >= 2);
            if (qa.size() > 0 && a_ready) void'(qa.pop_front());
            if (qb.size() > 0 && b_ready) void'(qb.pop_front());
            if (acc_a) begin
                if (a_sync) ka = 0;
                c = ka % 3;
                if (ma0[c]) qa.push_back(a_data[0]);
                if (ma1[c]) qa.push_back(a_data[1]);
                ka++;
            end
            if (acc_b) begin
                if (b_sync) kb = 0;
                c = kb % 2;
                if (mb0[c]) qb.push_back(b_data[0]);
                if (mb1[c]) qb.push_back(b_data[1]);
                kb++;
            end
        end
    end

    bit capa[$], capb[$];
    int va[$];
    bit pb_hold = 0;
    bit pb_data = 0;

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_ok) begin
            chk("a_ready", a_o_ready, (DEPTH - qa.size()) >= 2);
            chk("a_valid", a_o_valid, qa.size() > 0);
            if (qa.size() > 0) chk("a_data", a_o_data, qa[0]);
            chk("b_ready", b_o_ready, (DEPTH - qb.size()) >= 2);
            chk("b_valid", b_o_valid, qb.size() > 0);
            if (qb.size() > 0) chk("b_data", b_o_data, qb[0]);
            if (pb_hold && b_o_valid && rst_n) chk("b_stall_hold", b_o_data, pb_data);
            pb_hold = b_o_valid && !b_ready && rst_n;
            pb_data = b_o_data;
            if (a_o_valid && a_ready) capa.push_back(a_o_data);
            if (b_o_valid && b_ready) capb.push_back(b_o_data);
            if (a_o_valid) va.push_back(cyc);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [1:0] d, input logic s);
        bit rdy;
        int n;
        a_valid = 1'b1; a_data = d; a_sync = s; n = 0;
        do begin
            @(negedge clk); rdy = a_o_ready;
            @(posedge clk); #1; n++;
        end while (!rdy && n < 50);
        if (!rdy) begin
            checks++; errors++;
            $display("FAIL a_send_timeout: got no acceptance expected acceptance within 50 cycles");
        end
        a_valid = 1'b0; a_sync = 1'b0;
    endtask

    task automatic send_b(input logic [1:0] d);
        bit rdy;
        int n;
        b_valid = 1'b1; b_data = d; n = 0;
        do begin
            @(negedge clk); rdy = b_o_ready;
            @(posedge clk); #1; n++;
        end while (!rdy && n < 50);
        if (!rdy) begin
            checks++; errors++;
            $display("FAIL b_send_timeout: got no acceptance expected acceptance within 50 cycles");
        end
        b_valid = 1'b0;
    endtask

    bit b_tog = 0;
    always begin
        @(posedge clk); #1;
        if (b_tog) b_ready = ~b_ready;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    logic [1:0] st[12] = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b11, 2'b11,
                           2'b10, 2'b01, 2'b11, 2'b10, 2'b01, 2'b00};
    logic [1:0] vb[8]  = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b10, 2'b01, 2'b11, 2'b11};

    initial begin
        int acc0;
        int acc;
        rst_n = 1'b0;
        a_valid = 0; a_sync = 0; a_data = 0; a_ready = 1;
        b_valid = 0; b_sync = 0; b_data = 0; b_ready = 1;

        // Reset values while reset is held.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", a_o_valid, 1'b0);
        chk("rst_data",  a_o_data,  1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready_after", a_o_ready, 1'b1);
        @(posedge clk); #1;

        // Three back-to-back symbols from reset: 0,1,1,1 on four cycles.
        capa.delete(); va.delete();
        acc0 = cyc;
        send_a(2'b10, 0); send_a(2'b11, 0); send_a(2'b01, 0);
        idle(6);
        chk_bits("t_basic", capa, 16'b1110, 4);
        chk("t_basic_vcycles", va.size(), 4);
        if (va.size() == 4) begin
            chk("t_basic_first", va[0], acc0 + 1);
            chk("t_basic_run", va[3], va[0] + 3);
        end

        // Twelve random symbols: sixteen bits out.
        capa.delete();
        for (int i = 0; i < 12; i++) send_a(2'($urandom_range(0, 3)), 0);
        idle(20);
        chk("t_rand_len", capa.size(), 16);

        // Back-pressure: five symbols fill seven slots, then acceptance stops.
        capa.delete();
        a_ready = 0; acc = 0;
        for (int i = 0; i < 12; i++) begin
            a_valid = 1'b1; a_data = st[acc];
            @(negedge clk);
            if (a_o_ready) acc++;
            @(posedge clk); #1;
        end
        a_valid = 1'b0;
        chk("t_bp_accepted", acc, 5);
        chk("t_bp_ready_low", a_o_ready, 1'b0);
        a_ready = 1;
        idle(12);
        chk_bits("t_bp_drain", capa, 16'b1001101, 7);

        // Sync on the second symbol (column counter was at 2).
        capa.delete();
        send_a(2'b00, 0); send_a(2'b11, 1); send_a(2'b10, 0);
        idle(8);
        chk_bits("t_sync", capa, 16'b1110, 4);

        // Reset with five bits buffered.
        a_ready = 0;
        repeat (4) send_a(2'b11, 0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("t_rst_valid", a_o_valid, 1'b0);
        chk("t_rst_ready", a_o_ready, 1'b1);
        a_ready = 1;
        idle(1);
        capa.delete();
        send_a(2'b10, 0);
        idle(4);
        chk_bits("t_rst_col0", capa, 16'b10, 2);

        // Rate 2/3 configuration with alternating downstream ready.
        capb.delete();
        b_ready = 0; b_tog = 1;
        for (int i = 0; i < 8; i++) send_b(vb[i]);
        idle(30);
        b_tog = 0; b_ready = 1;
        idle(2);
        chk_bits("t_r23", capb, 16'b111110011001, 12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/viterbi_puncture.md
VITERBI_PUNCTURE -- requirements
Module: viterbi_puncture

Interface
REQ-001 SHALL have parameter p_speed_size, default 3, puncture period P in encoder symbols, legal range 2..8.
REQ-002 SHALL have parameter p_speed_pol0, default 3'b101, P-bit keep mask for coded bit 0; bit k applies to column k.
REQ-003 SHALL have parameter p_speed_pol1, default 3'b011, P-bit keep mask for coded bit 1; bit k applies to column k.
REQ-004 SHALL have parameter p_fifo_depth, default 8, output bit FIFO depth, power of two, >= 4.
REQ-005 i_clk  input  1  single clock, all logic on rising edge.
REQ-006 i_reset  input  1  synchronous, active-low reset.
REQ-007 i_data  input  2  encoder symbol; [0] from polynomial 0, [1] from polynomial 1.
REQ-008 i_valid  input  1  i_data valid; symbol accepted when i_valid && o_ready.
REQ-009 i_sync  input  1  sampled only on an accepted symbol; that symbol is taken as column 0.
REQ-010 o_ready  output  1  block can accept a symbol this cycle.
REQ-011 o_data  output  1  punctured serial bit.
REQ-012 o_valid  output  1  o_data valid; bit consumed when o_valid && i_ready.
REQ-013 i_ready  input  1  downstream accepts a bit this cycle.

Function
REQ-014 SHALL keep a column counter 0..P-1, advancing by one per accepted symbol, wrapping P-1 -> 0; i_sync on an accepted symbol forces that symbol to column 0, next to column 1.
REQ-015 For an accepted symbol at column c, SHALL push i_data[0] if p_speed_pol0[c]=1, then i_data[1] if p_speed_pol1[c]=1, in that order; 0, 1 or 2 bits per symbol.
REQ-016 A column with both mask bits 0 SHALL push nothing but still advance the counter.
REQ-017 o_ready SHALL be combinational from FIFO occupancy: high iff free entries >= 2 (independent of i_valid).
REQ-018 o_data/o_valid SHALL be the FIFO head; o_valid high iff occupancy >= 1.
REQ-019 Latency: a bit pushed in cycle N SHALL be visible on o_data in cycle N+1 when the FIFO was empty.
REQ-020 Simultaneous push (up to 2) and pop in one cycle SHALL update occupancy by pushes minus pop, never losing or duplicating a bit.
REQ-021 Occupancy SHALL never exceed p_fifo_depth; pointers SHALL wrap modulo p_fifo_depth.
REQ-022 o_data SHALL stay stable while o_valid && !i_ready.
REQ-023 Symbols presented with o_ready low SHALL be ignored (no counter advance, no push).

Reset
REQ-024 While i_reset=0 at a rising edge: column counter 0, FIFO empty, o_valid 0, o_data 0; o_ready 1 in the following cycle.
REQ-025 Reset mid-stream SHALL discard all buffered bits; the first symbol after reset is column 0.

Structure
REQ-026 Default puncture masks for rates 1/2, 2/3, 3/4 SHALL live in the shared viterbi constants include, reused by viterbi_speed_map.
REQ-027 The FIFO SHALL be a sub-module viterbi_bit_fifo (2-bit write port with per-bit enable, 1-bit read port, occupancy output).
REQ-028 Parameter check SHALL flag P outside 2..8 at elaboration.

Verification
REQ-029 Defaults, i_ready=1, symbols 2'b10, 2'b11, 2'b01 back-to-back from reset -> o_data 0,1,1,1 with o_valid 4 consecutive cycles starting 1 cycle after first acceptance.
REQ-030 Defaults, 12 random symbols, i_ready=1 -> exactly 16 bits out; decoded by viterbi_speed_map + viterbi_dec returns original data.
REQ-031 i_ready=0, i_valid=1 continuous -> o_ready falls when occupancy reaches 7; no further acceptance; releasing i_ready drains bits in order, no loss.
REQ-032 i_sync asserted on 2nd accepted symbol 2'b11 -> bits 1,1 emitted (column 0 rule), next symbol treated as column 1.
REQ-033 i_reset=0 for one cycle with 5 bits buffered -> next cycle o_valid=0, o_ready=1; next symbol handled as column 0.
REQ-034 P=2, pol0=2'b11, pol1=2'b01 (rate 2/3), alternating i_ready -> 3 bits per 2 symbols, o_data held stable across stalls.
